// File: rtl/iorq_port_fsm.sv
// iorq_port_fsm: Z80-style IORQ decoder issuing one-hot per-port rd/wr ticks (in: phi, reset, iorq, rd, wr, addr; out: rd_tick, wr_tick, busy, err)
module iorq_port_fsm #(
  parameter int AW = 8,
  parameter int NPORTS = 4,
  parameter logic [AW-1:0] BASE = 8'h40,
  parameter int QUAL_CYCLES = 2,
  parameter bit WR_TICK_AT_END = 1
) (
  input  logic              phi,
  input  logic              reset,
  input  logic              iorq,
  input  logic              rd,
  input  logic              wr,
  input  logic [AW-1:0]     addr,
  output logic [NPORTS-1:0] rd_tick,
  output logic [NPORTS-1:0] wr_tick,
  output logic              busy,
  output logic              err
);
  localparam int IW = NPORTS > 1 ? $clog2(NPORTS) : 1;
  typedef enum logic [1:0] {IDLE, QUAL, HOLD, IGNORE} state_t;
  state_t state, state_n;
  logic iorq_s, iorq_p, rd_s, wr_s;
  logic [AW-1:0] addr_s, off;
  logic [2:0] cnt, cnt_n;
  logic [IW-1:0] idx, idx_n;
  logic dir_wr, dir_wr_n, rd_p, wr_p, err_p, hit, start;
  assign off = addr_s - BASE;
  assign hit = addr_s >= BASE && {1'b0, off} < (AW+1)'(NPORTS);
  assign start = iorq_s & ~iorq_p;
  assign busy = state != IDLE;
  // Samples reset to iorq=1 so a cycle in flight at reset release needs a low sample first.
  always_ff @(posedge phi or posedge reset)
    if (reset) begin
      iorq_s <= 1'b1;
      iorq_p <= 1'b1;
      rd_s   <= 1'b0;
      wr_s   <= 1'b0;
      addr_s <= '0;
    end else begin
      iorq_p <= iorq_s;
      iorq_s <= iorq;
      rd_s   <= rd;
      wr_s   <= wr;
      addr_s <= addr;
    end
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    idx_n    = idx;
    dir_wr_n = dir_wr;
    rd_p     = 1'b0;
    wr_p     = 1'b0;
    err_p    = 1'b0;
    case (state)
      IDLE:
        if (start) begin
          idx_n    = off[IW-1:0];
          dir_wr_n = wr_s;
          cnt_n    = 3'd1;
          if (!hit || rd_s == wr_s) begin
            state_n = IGNORE;
            err_p   = hit & rd_s & wr_s;
          end else if (QUAL_CYCLES == 1) begin
            state_n = HOLD;
            rd_p    = rd_s;
            wr_p    = wr_s & !WR_TICK_AT_END;
          end else state_n = QUAL;
        end
      QUAL:
        if (!iorq_s) state_n = IDLE;
        else if (cnt + 3'd1 >= 3'(QUAL_CYCLES)) begin
          state_n = HOLD;
          rd_p    = !dir_wr;
          wr_p    = dir_wr & !WR_TICK_AT_END;
        end else cnt_n = cnt + 3'd1;
      HOLD:
        if (!iorq_s) begin
          state_n = IDLE;
          wr_p    = dir_wr & WR_TICK_AT_END;
        end
      default:
        if (!iorq_s) state_n = IDLE;
    endcase
  end
  always_ff @(posedge phi or posedge reset)
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      dir_wr  <= 1'b0;
      rd_tick <= '0;
      wr_tick <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      dir_wr  <= dir_wr_n;
      rd_tick <= rd_p ? NPORTS'(1) << idx_n : '0;
      wr_tick <= wr_p ? NPORTS'(1) << idx_n : '0;
      err     <= err_p;
    end
endmodule

// File: tb/tb_iorq_port_fsm.sv
// tb_iorq_port_fsm: randomized bus-cycle bench with a transaction-level expectation model
module tb_iorq_port_fsm;
  localparam int NP = 4;
  localparam int Q = 2;
  localparam logic [7:0] B = 8'h40;
  localparam int N = 2048;
  logic phi = 1'b0, reset = 1'b1, iorq = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [7:0] addr = '0;
  logic [NP-1:0] rd_tick, wr_tick, rd_tick0, wr_tick0;
  logic busy, err, busy0, err0;
  int checks = 0, errors = 0, ptr = 1, last;
  logic s_iorq[N], s_rd[N], s_wr[N], s_rst[N];
  logic [7:0] s_addr[N];
  logic [NP-1:0] x_rd[N], x_wr1[N], x_wr0[N];
  logic x_busy[N], x_err[N];
  always #25 phi = ~phi;
  iorq_port_fsm dut (
    .phi(phi), .reset(reset), .iorq(iorq), .rd(rd), .wr(wr), .addr(addr),
    .rd_tick(rd_tick), .wr_tick(wr_tick), .busy(busy), .err(err)
  );
  iorq_port_fsm #(.WR_TICK_AT_END(0)) dut0 (
    .phi(phi), .reset(reset), .iorq(iorq), .rd(rd), .wr(wr), .addr(addr),
    .rd_tick(rd_tick0), .wr_tick(wr_tick0), .busy(busy0), .err(err0)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask
  // One bus cycle: gap low samples, then len high samples; expectations come from
  // the first high sample (edge n) only, later addr/rd/wr values are noise.
  task automatic add(input int gap, input int len, input logic [7:0] a, input logic r,
                     input logic w, input bit kill);
    int n, idx, rr;
    bit hit;
    for (int i = 0; i < gap; i++) begin
      s_iorq[ptr+i] = 1'b0;
      s_addr[ptr+i] = 8'($urandom);
      s_rd[ptr+i]   = 1'($urandom);
      s_wr[ptr+i]   = 1'($urandom);
    end
    n = ptr + gap;
    for (int i = 0; i < len; i++) begin
      s_iorq[n+i] = 1'b1;
      s_addr[n+i] = i == 0 ? a : 8'($urandom_range(8'h3e, 8'h45));
      s_rd[n+i]   = i == 0 ? r : 1'($urandom);
      s_wr[n+i]   = i == 0 ? w : 1'($urandom);
    end
    hit = a >= B && a < B + NP;
    idx = int'(a) - int'(B);
    for (int k = n + 1; k <= n + len; k++) x_busy[k] = 1'b1;
    if (hit && r && w) x_err[n+1] = 1'b1;
    else if (hit && r != w && len >= Q) begin
      if (r) x_rd[n+Q][idx] = 1'b1;
      else begin
        x_wr1[n+len+1][idx] = 1'b1;
        x_wr0[n+Q][idx] = 1'b1;
      end
    end
    if (kill) begin
      rr = $urandom_range(n + Q + 1, n + len - 2);
      s_rst[rr] = 1'b1;
      for (int k = rr; k <= n + len + 1; k++) begin
        x_rd[k] = '0;
        x_wr1[k] = '0;
        x_wr0[k] = '0;
        x_busy[k] = 1'b0;
        x_err[k] = 1'b0;
      end
    end
    ptr = n + len;
  endtask
  initial begin
    int len;
    logic prev;
    for (int e = 0; e < N; e++) begin
      s_iorq[e] = 1'b0; s_rd[e] = 1'b0; s_wr[e] = 1'b0; s_rst[e] = 1'b0; s_addr[e] = '0;
      x_rd[e] = '0; x_wr1[e] = '0; x_wr0[e] = '0; x_busy[e] = 1'b0; x_err[e] = 1'b0;
    end
    s_rst[0] = 1'b1;
    add(3, 4, 8'h42, 1'b1, 1'b0, 1'b0);
    add(2, 4, 8'h41, 1'b0, 1'b1, 1'b0);
    add(2, 1, 8'h40, 1'b1, 1'b0, 1'b0);
    add(2, 3, 8'h44, 1'b1, 1'b0, 1'b0);
    add(2, 3, 8'h40, 1'b1, 1'b1, 1'b0);
    add(2, 3, 8'h43, 1'b0, 1'b0, 1'b0);
    add(2, 2, 8'h43, 1'b1, 1'b0, 1'b0);
    add(1, 2, 8'h40, 1'b0, 1'b1, 1'b0);
    add(2, 7, 8'h41, 1'b0, 1'b1, 1'b1);
    add(2, 4, 8'h41, 1'b0, 1'b1, 1'b0);
    while (ptr < N - 40) begin
      len = $urandom_range(1, 8);
      add($urandom_range(1, 3), len, 8'($urandom_range(8'h3e, 8'h45)), 1'($urandom),
          1'($urandom), len >= Q + 3 && $urandom_range(0, 7) == 0);
    end
    last = ptr + 4;
    for (int e = 0; e <= last; e++) begin
      @(negedge phi);
      prev  = reset;
      reset = s_rst[e];
      iorq  = s_iorq[e];
      rd    = s_rd[e];
      wr    = s_wr[e];
      addr  = s_addr[e];
      if (reset && !prev) begin
        #1;
        check("async_busy", busy, 1'b0);
        check("async_wr", wr_tick, '0);
        check("async_busy0", busy0, 1'b0);
      end
      @(posedge phi);
      #1;
      check("rd_tick", rd_tick, x_rd[e]);
      check("wr_tick_end", wr_tick, x_wr1[e]);
      check("busy", busy, x_busy[e]);
      check("err", err, x_err[e]);
      check("rd_tick0", rd_tick0, x_rd[e]);
      check("wr_tick_qual", wr_tick0, x_wr0[e]);
      check("busy0", busy0, x_busy[e]);
      check("err0", err0, x_err[e]);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iorq_port_fsm.md
IORQ_PORT_FSM -- requirements
Module: iorq_port_fsm

Interface
REQ-001 SHALL have parameter AW, default 8: I/O address width in bits.
REQ-002 SHALL have parameter NPORTS, default 4: number of decoded ports, range 1..16.
REQ-003 SHALL have parameter BASE, default 8'h40: address of port 0; port i is at BASE+i.
REQ-004 SHALL have parameter QUAL_CYCLES, default 2: consecutive high iorq samples needed before a cycle is accepted, range 1..7.
REQ-005 SHALL have parameter WR_TICK_AT_END, default 1: 1 = write tick fires at cycle end; 0 = write tick fires at qualification, as reads do.
REQ-006 SHALL have port phi, input, 1 bit: system clock; all logic on the rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port iorq, input, 1 bit: CPU IORQ, positive logic.
REQ-009 SHALL have port rd, input, 1 bit: CPU RD, positive logic.
REQ-010 SHALL have port wr, input, 1 bit: CPU WR, positive logic.
REQ-011 SHALL have port addr, input, AW bits: CPU I/O address.
REQ-012 SHALL have port rd_tick, output, NPORTS bits: one-hot, one-phi read strobe per port.
REQ-013 SHALL have port wr_tick, output, NPORTS bits: one-hot, one-phi write strobe per port.
REQ-014 SHALL have port busy, output, 1 bit: high while the FSM is not in IDLE.
REQ-015 SHALL have port err, output, 1 bit: one-phi pulse when a decode-hit cycle has rd and wr both high.

Function
REQ-016 SHALL register iorq, rd, wr and addr on every phi rising edge; the FSM SHALL use only these registered samples.
REQ-017 SHALL start a cycle only on a sampled iorq rising edge: current sample 1, previous sample 0.
REQ-018 SHALL have states IDLE, QUAL, HOLD, IGNORE.
REQ-019 IDLE -> QUAL on a start with a decode hit: sampled addr within BASE..BASE+NPORTS-1.
  - Port index (addr-BASE) and direction latched at that edge.
REQ-020 IDLE -> IGNORE on a start with a decode miss, or with neither rd nor wr sampled high.
REQ-021 QUAL SHALL count consecutive high iorq samples.
  - Sampled iorq low before the count reaches QUAL_CYCLES -> IDLE, no tick.
REQ-022 When the count reaches QUAL_CYCLES, the FSM SHALL go QUAL -> HOLD.
  - Read cycle: rd_tick[index] high for exactly one phi cycle.
  - Write with WR_TICK_AT_END=0: wr_tick[index] high for exactly one phi cycle.
REQ-023 Read tick latency: if edge n is the first edge sampling iorq&rd high, rd_tick SHALL be high during the cycle following edge n+QUAL_CYCLES.
REQ-024 HOLD and IGNORE SHALL return to IDLE on the first sampled iorq low.
  - Write with WR_TICK_AT_END=1 leaving HOLD: wr_tick[index] pulses for one phi cycle on that transition.
REQ-025 A decode-hit start with rd and wr both sampled high SHALL pulse err for one cycle, go to IGNORE, and produce no tick.
REQ-026 At most one bit of rd_tick|wr_tick SHALL be high in any cycle; at most one tick per IORQ assertion.
REQ-027 Address or rd/wr changes after the start SHALL NOT alter the latched index or direction.
REQ-028 A new start in the same cycle that HOLD/IGNORE returns to IDLE is impossible by REQ-017; the next cycle SHALL need a fresh low-to-high iorq sample.

Reset
REQ-029 Reset SHALL force IDLE, the count to 0, and rd_tick, wr_tick, busy and err to 0 immediately, without waiting for phi.
REQ-030 Reset SHALL set the previous-iorq sample to 1, so a cycle already in progress at reset release is ignored until iorq is sampled low.
REQ-031 Reset mid-cycle SHALL suppress any pending tick, including an end-of-cycle write tick.

Verification
REQ-032 Bench phi period 50 ns. Scenario: read addr 8'h42, iorq/rd high for 4 phi cycles (T1-T2-TW-T3), defaults -> rd_tick = 4'b0100 for one cycle at edge n+2; wr_tick stays 0.
REQ-033 Write addr 8'h41, iorq/wr high 4 cycles, WR_TICK_AT_END=1 -> wr_tick = 4'b0010 for one cycle on the first edge after iorq is sampled low; with WR_TICK_AT_END=0 the pulse is at edge n+2.
REQ-034 Short cycle: iorq/rd high for 1 phi cycle at addr 8'h40, QUAL_CYCLES=2 -> no tick, busy high for one cycle, then IDLE.
REQ-035 Decode miss and illegal direction:
  - Read at 8'h44 -> no tick, busy high until iorq low.
  - rd&wr both high at 8'h40 -> err one-cycle pulse, no tick.
REQ-036 Reset is asserted for 1 cycle during HOLD of a write and released while iorq is still high -> no wr_tick; busy stays 0 until the next fresh cycle, which ticks normally.
